mem_arbiter: RTL and testbench

- Shares one memory_controller port between two requesters, M0 and M1. Typical pairing: function_expander on M0, an instruction/packet fetch unit on M1.
- Requests are granted one at a time in round-robin order and forwarded to the memory side with a valid/ready handshake.
- A tag FIFO records the requester ID of every accepted read, in order. In-order read responses from memory are steered back to the requester that issued them.

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory_controller request port between two
// requesters (M0, M1) and steers in-order read responses back to the issuer.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   Mi_SEND_ADDR_VALID     request valid from requester i
//   Mi_SEND_ADDR / _DATA   byte address / write data from requester i
//   Mi_SEND_DATA_VALID     1 = write, 0 = read
//   Mi_SEND_READY          request from requester i accepted this cycle
//   Mi_RECEIVE_VALID/DATA  read response to requester i
//   Mi_RECEIVE_READY       requester i can take read data
//   MEM_SEND_*             registered request towards memory_controller
//   MEM_RECEIVE_*          in-order read responses from memory_controller
//
// Requests are granted one at a time, round-robin on ties. Each accepted read
// pushes its requester ID into a small tag FIFO; the FIFO head selects which
// requester sees the next memory response.
module mem_arbiter #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic        CLK,
  input  logic        RST,

  input  logic        M0_SEND_ADDR_VALID,
  input  logic [31:0] M0_SEND_ADDR,
  input  logic        M0_SEND_DATA_VALID,
  input  logic [31:0] M0_SEND_DATA,
  output logic        M0_SEND_READY,
  output logic        M0_RECEIVE_VALID,
  output logic [31:0] M0_RECEIVE_DATA,
  input  logic        M0_RECEIVE_READY,

  input  logic        M1_SEND_ADDR_VALID,
  input  logic [31:0] M1_SEND_ADDR,
  input  logic        M1_SEND_DATA_VALID,
  input  logic [31:0] M1_SEND_DATA,
  output logic        M1_SEND_READY,
  output logic        M1_RECEIVE_VALID,
  output logic [31:0] M1_RECEIVE_DATA,
  input  logic        M1_RECEIVE_READY,

  output logic        MEM_SEND_ADDR_VALID,
  output logic [31:0] MEM_SEND_ADDR,
  output logic        MEM_SEND_DATA_VALID,
  output logic [31:0] MEM_SEND_DATA,
  input  logic        MEM_SEND_READY,
  input  logic        MEM_RECEIVE_VALID,
  input  logic [31:0] MEM_RECEIVE_DATA,
  output logic        MEM_RECEIVE_READY
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = (PTR_WIDTH)'(1);

  state_t              state_r;
  state_t              state_next_s;

  logic                last_r;        // requester that won the previous grant
  logic [31:0]         send_addr_r;
  logic [31:0]         send_data_r;
  logic                send_wr_r;

  logic [DEPTH-1:0]    tag_mem_r;     // one requester ID bit per outstanding read
  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [PTR_WIDTH:0]  count_r;

  logic                full_s;
  logic                elig0_s;
  logic                elig1_s;
  logic                grant_valid_s;
  logic                grant_id_s;
  logic                accept_s;
  logic [31:0]         sel_addr_s;
  logic [31:0]         sel_data_s;
  logic                sel_wr_s;
  logic                push_s;
  logic                pop_s;
  logic                head_s;
  logic                nonempty_s;

  // A read is only eligible while the tag FIFO has room; writes never need a tag.
  assign full_s  = (count_r == FULL_COUNT);
  assign elig0_s = M0_SEND_ADDR_VALID && (M0_SEND_DATA_VALID || !full_s);
  assign elig1_s = M1_SEND_ADDR_VALID && (M1_SEND_DATA_VALID || !full_s);

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (elig0_s && elig1_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_r;
    end else if (elig0_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (elig1_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign sel_addr_s = grant_id_s ? M1_SEND_ADDR       : M0_SEND_ADDR;
  assign sel_data_s = grant_id_s ? M1_SEND_DATA       : M0_SEND_DATA;
  assign sel_wr_s   = grant_id_s ? M1_SEND_DATA_VALID : M0_SEND_DATA_VALID;

  assign accept_s = M0_SEND_READY || M1_SEND_READY;
  assign push_s   = accept_s && !sel_wr_s;

  // Response steering: the FIFO head names the requester of the oldest read.
  assign nonempty_s        = (count_r != {(PTR_WIDTH + 1){1'b0}});
  assign head_s            = tag_mem_r[rd_ptr_r];
  assign MEM_RECEIVE_READY = nonempty_s && (head_s ? M1_RECEIVE_READY : M0_RECEIVE_READY);
  assign M0_RECEIVE_VALID  = MEM_RECEIVE_VALID && nonempty_s && !head_s;
  assign M1_RECEIVE_VALID  = MEM_RECEIVE_VALID && nonempty_s && head_s;
  assign M0_RECEIVE_DATA   = MEM_RECEIVE_DATA;
  assign M1_RECEIVE_DATA   = MEM_RECEIVE_DATA;
  assign pop_s             = MEM_RECEIVE_VALID && MEM_RECEIVE_READY;

  assign MEM_SEND_ADDR       = send_addr_r;
  assign MEM_SEND_DATA       = send_data_r;
  assign MEM_SEND_DATA_VALID = send_wr_r;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: IDLE until a request is accepted, SEND until memory takes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_SEND;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (MEM_SEND_READY) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_SEND;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs: grants only while idle, memory request valid only while sending.
  always_comb begin
    M0_SEND_READY       = 1'b0;
    M1_SEND_READY       = 1'b0;
    MEM_SEND_ADDR_VALID = 1'b0;
    case (state_r)
      S_IDLE: begin
        M0_SEND_READY = grant_valid_s && !grant_id_s;
        M1_SEND_READY = grant_valid_s && grant_id_s;
      end
      S_SEND: begin
        MEM_SEND_ADDR_VALID = 1'b1;
      end
      default: begin
        M0_SEND_READY       = 1'b0;
        M1_SEND_READY       = 1'b0;
        MEM_SEND_ADDR_VALID = 1'b0;
      end
    endcase
  end

  // Request holding registers and round-robin history, loaded on acceptance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      send_addr_r <= 32'h0000_0000;
      send_data_r <= 32'h0000_0000;
      send_wr_r   <= 1'b0;
      last_r      <= 1'b1;
    end else if (accept_s) begin
      send_addr_r <= sel_addr_s;
      send_data_r <= sel_data_s;
      send_wr_r   <= sel_wr_s;
      last_r      <= grant_id_s;
    end
  end

  // Tag FIFO: push on accepted read, pop on delivered response; the full check
  // above uses the pre-pop count, so a same-cycle push and pop keep count steady.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_mem_r <= {DEPTH{1'b0}};
      wr_ptr_r  <= {PTR_WIDTH{1'b0}};
      rd_ptr_r  <= {PTR_WIDTH{1'b0}};
      count_r   <= {(PTR_WIDTH + 1){1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_id_s;
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model (pending
// request record, queue of outstanding read owners, sparse memory image and
// per-requester expected-data queues) predicts every DUT output each cycle.
module tb_mem_arbiter;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        req_v    [2];
  logic [31:0] req_addr [2];
  logic        req_wr   [2];
  logic [31:0] req_data [2];
  logic        rr       [2];
  logic        mem_srdy;
  logic        mem_rv;
  logic [31:0] mem_rd;

  logic        m0_srdy, m1_srdy, m0_rv, m1_rv;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_av, mem_dv, mem_rr;
  logic [31:0] mem_a, mem_d;

  mem_arbiter #(.DEPTH(4), .PTR_WIDTH(2)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .M0_SEND_ADDR_VALID (req_v[0]),
    .M0_SEND_ADDR       (req_addr[0]),
    .M0_SEND_DATA_VALID (req_wr[0]),
    .M0_SEND_DATA       (req_data[0]),
    .M0_SEND_READY      (m0_srdy),
    .M0_RECEIVE_VALID   (m0_rv),
    .M0_RECEIVE_DATA    (m0_rd),
    .M0_RECEIVE_READY   (rr[0]),
    .M1_SEND_ADDR_VALID (req_v[1]),
    .M1_SEND_ADDR       (req_addr[1]),
    .M1_SEND_DATA_VALID (req_wr[1]),
    .M1_SEND_DATA       (req_data[1]),
    .M1_SEND_READY      (m1_srdy),
    .M1_RECEIVE_VALID   (m1_rv),
    .M1_RECEIVE_DATA    (m1_rd),
    .M1_RECEIVE_READY   (rr[1]),
    .MEM_SEND_ADDR_VALID(mem_av),
    .MEM_SEND_ADDR      (mem_a),
    .MEM_SEND_DATA_VALID(mem_dv),
    .MEM_SEND_DATA      (mem_d),
    .MEM_SEND_READY     (mem_srdy),
    .MEM_RECEIVE_VALID  (mem_rv),
    .MEM_RECEIVE_DATA   (mem_rd),
    .MEM_RECEIVE_READY  (mem_rr)
  );

  // ---------------- reference model state ----------------
  bit          p_v;            // request waiting for memory handshake
  logic [31:0] p_addr, p_data;
  bit          p_wr;
  int          p_id;
  int          last_id;
  int          tagq[$];        // owners of outstanding reads, oldest first
  logic [31:0] rspq[$];        // responses the memory side owes, in order
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];
  logic [31:0] store [logic [31:0]];

  int  win;
  bit  exp_mrr;
  bit  acc_last [2];
  bit  popped_last;
  int  errors = 0;
  int  checks = 0;
  int  cyc_n  = 0;

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc_n, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc_n, act, exp);
    end
  endtask

  // Settle, predict from model + inputs, compare every output.
  task automatic eval();
    int cnt;
    int head;
    bit e0, e1;
    #1;
    win     = -1;
    exp_mrr = 1'b0;
    if (RST) return;
    cnt  = tagq.size();
    e0   = req_v[0] && (req_wr[0] || cnt < DEPTH);
    e1   = req_v[1] && (req_wr[1] || cnt < DEPTH);
    if (!p_v) begin
      if (e0 && e1)  win = 1 - last_id;
      else if (e0)   win = 0;
      else if (e1)   win = 1;
    end
    head = (cnt != 0) ? tagq[0] : -1;
    if (cnt != 0) exp_mrr = rr[head];
    chk1("m0_send_ready", m0_srdy, win == 0);
    chk1("m1_send_ready", m1_srdy, win == 1);
    chk1("mem_send_addr_valid", mem_av, p_v);
    if (p_v) begin
      chk32("mem_send_addr", mem_a, p_addr);
      chk32("mem_send_data", mem_d, p_data);
      chk1("mem_send_data_valid", mem_dv, p_wr);
    end
    chk1("mem_receive_ready", mem_rr, exp_mrr);
    chk1("m0_receive_valid", m0_rv, mem_rv && cnt != 0 && head == 0);
    chk1("m1_receive_valid", m1_rv, mem_rv && cnt != 0 && head == 1);
    if (mem_rv) begin
      chk32("m0_receive_data", m0_rd, mem_rd);
      chk32("m1_receive_data", m1_rd, mem_rd);
    end
  endtask

  // Apply the clock edge to the model, then move to the next falling edge.
  task automatic advance();
    int id;
    logic [31:0] d;
    acc_last    = '{1'b0, 1'b0};
    popped_last = 1'b0;
    if (RST) begin
      p_v     = 1'b0;
      last_id = 1;
      tagq.delete();
      rspq.delete();
      expq0.delete();
      expq1.delete();
    end else begin
      if (mem_rv && exp_mrr) begin
        popped_last = 1'b1;
        id = tagq.pop_front();
        if (rspq.size() > 0) void'(rspq.pop_front());
        if (id == 0 && expq0.size() > 0) chk32("m0_delivered_data", m0_rd, expq0.pop_front());
        if (id == 1 && expq1.size() > 0) chk32("m1_delivered_data", m1_rd, expq1.pop_front());
      end
      if (p_v && mem_srdy) begin
        if (p_wr) begin
          store[p_addr] = p_data;
        end else begin
          d = mem_value(p_addr);
          rspq.push_back(d);
          if (p_id == 0) expq0.push_back(d);
          else           expq1.push_back(d);
        end
        p_v = 1'b0;
      end else if (win >= 0) begin
        p_v     = 1'b1;
        p_addr  = req_addr[win];
        p_data  = req_data[win];
        p_wr    = req_wr[win];
        p_id    = win;
        last_id = win;
        acc_last[win] = 1'b1;
        if (!p_wr) tagq.push_back(win);
      end
    end
    @(negedge CLK);
    cyc_n++;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      req_v[i]    = 1'b0;
      req_addr[i] = 32'h0;
      req_wr[i]   = 1'b0;
      req_data[i] = 32'h0;
      rr[i]       = 1'b0;
    end
    mem_srdy = 1'b0;
    mem_rv   = 1'b0;
    mem_rd   = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    eval();
    advance();
    RST = 1'b0;
  endtask

  task automatic present_response();
    mem_rv = (rspq.size() > 0);
    mem_rd = mem_rv ? rspq[0] : 32'h0;
  endtask

  task automatic gen_random(input int n);
    int rsp_prob;
    case ((n / 200) % 3)
      0:       rsp_prob = 10;
      1:       rsp_prob = 90;
      default: rsp_prob = 50;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (acc_last[i]) req_v[i] = 1'b0;
      if (!req_v[i] && $urandom_range(99) < 40) begin
        req_v[i]    = 1'b1;
        req_addr[i] = 32'h40 + 32'($urandom_range(7)) * 32'h4;
        req_wr[i]   = ($urandom_range(99) < 30);
        req_data[i] = $urandom;
      end
      rr[i] = ($urandom_range(99) < 75);
    end
    mem_srdy = ($urandom_range(99) < 60);
    if (!(mem_rv && !popped_last && rspq.size() > 0)) begin
      mem_rv = 1'b0;
      if (rspq.size() > 0 && $urandom_range(99) < rsp_prob) begin
        mem_rv = 1'b1;
        mem_rd = rspq[0];
      end else if (tagq.size() == 0 && $urandom_range(99) < 5) begin
        mem_rv = 1'b1;              // stray response: must stall, never delivered
        mem_rd = $urandom;
      end
    end
  endtask

  int grants[$];
  int exp_g [4] = '{0, 1, 0, 1};

  initial begin
    last_id = 1;
    p_v     = 1'b0;
    RST     = 1'b1;
    idle_inputs();
    @(negedge CLK);
    do_reset();

    // Reset state.
    eval();
    chk1 ("rst_mem_addr_valid", mem_av, 1'b0);
    chk32("rst_mem_addr", mem_a, 32'h0);
    chk32("rst_mem_data", mem_d, 32'h0);
    chk1 ("rst_mem_data_valid", mem_dv, 1'b0);
    chk1 ("rst_mem_receive_ready", mem_rr, 1'b0);
    advance();

    // Single read of 0x100, response 3 cycles after the request reaches memory.
    store[32'h100] = 32'hDEAD_BEEF;
    req_v[0] = 1'b1; req_addr[0] = 32'h100; req_wr[0] = 1'b0; mem_srdy = 1'b1;
    eval(); chk1("t1_m0_ready", m0_srdy, 1'b1); advance();
    req_v[0] = 1'b0;
    eval(); chk1("t1_mem_valid", mem_av, 1'b1); chk32("t1_mem_addr", mem_a, 32'h100); advance();
    repeat (2) begin eval(); advance(); end
    mem_rv = 1'b1; mem_rd = 32'hDEAD_BEEF; rr[0] = 1'b1; rr[1] = 1'b1;
    eval();
    chk1 ("t1_m0_rvalid", m0_rv, 1'b1);
    chk32("t1_m0_rdata", m0_rd, 32'hDEAD_BEEF);
    chk1 ("t1_m1_rvalid", m1_rv, 1'b0);
    advance();
    mem_rv = 1'b0;

    // Contention: both hold reads, grants must alternate starting with M0.
    do_reset();
    req_v[0] = 1'b1; req_addr[0] = 32'h10;
    req_v[1] = 1'b1; req_addr[1] = 32'h20;
    rr[0] = 1'b1; rr[1] = 1'b1; mem_srdy = 1'b1;
    repeat (8) begin
      present_response();
      eval();
      if (m0_srdy) grants.push_back(0);
      if (m1_srdy) grants.push_back(1);
      advance();
    end
    chk32("t2_grant_count", grants.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < grants.size()) chk32($sformatf("t2_grant%0d", k), grants[k], exp_g[k]);
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (4) begin present_response(); eval(); advance(); end

    // Reset while stuck in the send phase with two reads outstanding.
    do_reset();
    mem_srdy = 1'b1;
    req_v[0] = 1'b1; req_addr[0] = 32'h80;
    eval(); advance();
    req_v[0] = 1'b0;
    eval(); advance();
    req_v[1] = 1'b1; req_addr[1] = 32'h84;
    eval(); advance();
    req_v[1] = 1'b0; mem_srdy = 1'b0;
    eval(); chk1("t3_stuck_valid", mem_av, 1'b1); advance();
    do_reset();
    req_v[0] = 1'b1; req_addr[0] = 32'h88;
    req_v[1] = 1'b1; req_addr[1] = 32'h8C;
    rr[0] = 1'b1; rr[1] = 1'b1;
    eval();
    chk1("t3_mem_valid_cleared", mem_av, 1'b0);
    chk1("t3_fifo_empty", mem_rr, 1'b0);
    chk1("t3_tie_m0", m0_srdy, 1'b1);
    chk1("t3_tie_m1", m1_srdy, 1'b0);
    advance();

    // FIFO full: four reads outstanding block the fifth until a pop.
    do_reset();
    mem_srdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_v[0] = 1'b1; req_addr[0] = 32'h200 + 32'(k) * 32'h4;
      eval(); advance();
      req_v[0] = 1'b0;
      eval(); advance();
    end
    chk32("t4_model_count_full", tagq.size(), 32'd4);
    req_v[0] = 1'b1; req_addr[0] = 32'h300;
    repeat (3) begin eval(); chk1("t4_full_blocks", m0_srdy, 1'b0); advance(); end
    mem_rv = 1'b1; mem_rd = rspq[0]; rr[0] = 1'b1;
    eval(); chk1("t4_no_bypass", m0_srdy, 1'b0); chk1("t4_pop_ready", mem_rr, 1'b1); advance();
    mem_rv = 1'b0;
    eval(); chk1("t4_ready_after_pop", m0_srdy, 1'b1); advance();
    chk32("t4_model_count_refill", tagq.size(), 32'd4);
    req_v[0] = 1'b0;
    eval(); advance();
    req_v[0] = 1'b1; req_addr[0] = 32'h304;
    eval(); chk1("t4_full_again", m0_srdy, 1'b0); advance();
    req_v[0] = 1'b0;

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 1500 || n == 3000) begin
        do_reset();
      end else begin
        gen_random(n);
        eval();
        advance();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
